param_package_sorter: RTL and testbench

- Parametrised next-generation package sorter for the scale front end.
- Classifies a settled scale weight into one of NUM_GRP bins using runtime-programmable upper thresholds, and counts exactly one package per load/unload cycle.
- Per-bin counters saturate and carry sticky saturation flags.
- Sits between the scale ADC register and the display/report logic.

---
 rtl/param_package_sorter_if.sv | 30 +++
 rtl/param_package_sorter.sv | 148 ++++++++++++++
 tb/tb_param_package_sorter.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/param_package_sorter_if.sv
// Bus bundle for the package sorter: scale sample and config in, counters and strobes out.
// The slave modport belongs to the sorter and the master modport belongs to whatever drives the scale/config side.
interface param_package_sorter_if #(
  parameter int WEIGHT_W = 12,
  parameter int CNT_W    = 8,
  parameter int NUM_GRP  = 6
);
  logic [WEIGHT_W-1:0]      weight;
  logic                     cfg_we;
  logic [2:0]               cfg_idx;
  logic [WEIGHT_W-1:0]      cfg_data;
  logic                     clr_cnt;
  logic [NUM_GRP*CNT_W-1:0] grp_cnt;
  logic [NUM_GRP-1:0]       grp_sat;
  logic [2:0]               currgrp;
  logic [WEIGHT_W-1:0]      prevweight;
  logic                     count_pulse;
  logic [2:0]               count_grp;
  logic [1:0]               fsm_state;

  modport master (
    output weight, cfg_we, cfg_idx, cfg_data, clr_cnt,
    input  grp_cnt, grp_sat, currgrp, prevweight, count_pulse, count_grp, fsm_state
  );

  modport slave (
    input  weight, cfg_we, cfg_idx, cfg_data, clr_cnt,
    output grp_cnt, grp_sat, currgrp, prevweight, count_pulse, count_grp, fsm_state
  );
endinterface

// File: rtl/param_package_sorter.sv
// Package sorter: bins a settled scale weight against programmable upper thresholds
// and counts one package per load/unload cycle into saturating per-group counters.
module param_package_sorter #(
  parameter int WEIGHT_W      = 12,
  parameter int CNT_W         = 8,
  parameter int NUM_GRP       = 6,
  parameter int STABLE_CYCLES = 2,
  parameter logic [(NUM_GRP-1)*WEIGHT_W-1:0] THR_INIT =
    {12'd2000, 12'd1500, 12'd750, 12'd500, 12'd250}
) (
  input logic                  clk,
  input logic                  reset,
  param_package_sorter_if.slave bus
);

  localparam logic [1:0] S_EMPTY    = 2'd0;
  localparam logic [1:0] S_SETTLING = 2'd1;
  localparam logic [1:0] S_COUNTED  = 2'd2;

  logic [WEIGHT_W-1:0] thr [NUM_GRP-1];
  logic [CNT_W-1:0]    cnt [NUM_GRP];
  logic [NUM_GRP-1:0]  sat;
  logic [1:0]          state, state_nxt;
  logic [WEIGHT_W-1:0] cap;
  logic [3:0]          stab, stab_nxt, stab_inc;
  logic                cap_ld, count_evt;
  logic [2:0]          cls;
  logic [2:0]          currgrp_q, count_grp_q;
  logic [WEIGHT_W-1:0] prevweight_q;
  logic                count_pulse_q;

  // Lowest-index matching threshold wins, so iterate from the top down.
  // Note: with NUM_GRP=8 the top group does not fit the 3-bit group code.
  always_comb begin
    cls = 3'(NUM_GRP);
    for (int g = NUM_GRP-1; g >= 1; g--) begin
      if (bus.weight <= thr[g-1]) cls = 3'(g);
    end
    if (bus.weight == '0) cls = 3'd0;
  end

  always_comb begin
    state_nxt = state;
    stab_nxt  = stab;
    stab_inc  = stab + 4'd1;
    cap_ld    = 1'b0;
    count_evt = 1'b0;
    case (state)
      S_EMPTY: begin
        if (bus.weight != '0) begin
          cap_ld   = 1'b1;
          stab_nxt = 4'd1;
          if (STABLE_CYCLES == 1) begin
            count_evt = 1'b1;
            state_nxt = S_COUNTED;
          end else begin
            state_nxt = S_SETTLING;
          end
        end
      end
      S_SETTLING: begin
        if (bus.weight == '0) begin
          state_nxt = S_EMPTY;
        end else if (bus.weight != cap) begin
          cap_ld   = 1'b1;
          stab_nxt = 4'd1;
        end else begin
          stab_nxt = stab_inc;
          if (stab_inc == 4'(STABLE_CYCLES)) begin
            count_evt = 1'b1;
            state_nxt = S_COUNTED;
          end
        end
      end
      S_COUNTED: begin
        if (bus.weight == '0) state_nxt = S_EMPTY;
      end
      default: state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_EMPTY;
      stab  <= 4'd0;
      cap   <= '0;
    end else begin
      state <= state_nxt;
      stab  <= stab_nxt;
      if (cap_ld) cap <= bus.weight;
    end
  end

  // A write changes classification only from the following cycle on.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_GRP-1; i++) thr[i] <= THR_INIT[i*WEIGHT_W +: WEIGHT_W];
    end else begin
      for (int i = 0; i < NUM_GRP-1; i++) begin
        if (bus.cfg_we && bus.cfg_idx == 3'(i)) thr[i] <= bus.cfg_data;
      end
    end
  end

  // Clear has priority over a coincident count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int g = 0; g < NUM_GRP; g++) cnt[g] <= '0;
      sat <= '0;
    end else if (bus.clr_cnt) begin
      for (int g = 0; g < NUM_GRP; g++) cnt[g] <= '0;
      sat <= '0;
    end else if (count_evt) begin
      for (int g = 0; g < NUM_GRP; g++) begin
        if (cls == 3'(g+1)) begin
          if (cnt[g] == {CNT_W{1'b1}}) sat[g] <= 1'b1;
          else                         cnt[g] <= cnt[g] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      currgrp_q     <= 3'd0;
      prevweight_q  <= '0;
      count_pulse_q <= 1'b0;
      count_grp_q   <= 3'd0;
    end else begin
      currgrp_q     <= cls;
      prevweight_q  <= bus.weight;
      count_pulse_q <= count_evt;
      if (count_evt) count_grp_q <= cls;
    end
  end

  for (genvar g = 0; g < NUM_GRP; g++) begin : g_pack
    assign bus.grp_cnt[g*CNT_W +: CNT_W] = cnt[g];
  end

  assign bus.grp_sat     = sat;
  assign bus.currgrp     = currgrp_q;
  assign bus.prevweight  = prevweight_q;
  assign bus.count_pulse = count_pulse_q;
  assign bus.count_grp   = count_grp_q;
  assign bus.fsm_state   = state;

endmodule

// File: tb/tb_param_package_sorter.sv
// Directed bench for param_package_sorter: a default instance plus a CNT_W=2 instance for saturation.
module tb_param_package_sorter;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  logic [2:0] exp_q[$];
  logic [2:0] exp_qb[$];

  param_package_sorter_if #(.CNT_W(8)) a_if ();
  param_package_sorter_if #(.CNT_W(2)) b_if ();

  param_package_sorter #(.CNT_W(8)) u_a (.clk(clk), .reset(rst_n), .bus(a_if.slave));
  param_package_sorter #(.CNT_W(2)) u_b (.clk(clk), .reset(rst_n), .bus(b_if.slave));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] cnt_a(input int g);
    return 8'(a_if.grp_cnt >> ((g-1)*8));
  endfunction

  // scoreboard monitors
  always @(negedge clk) begin
    if (rst_n && a_if.count_pulse) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_count_a: got group %0d expected no count", a_if.count_grp);
      end else begin
        check("count_grp_a", 32'(a_if.count_grp), 32'(exp_q.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && b_if.count_pulse) begin
      if (exp_qb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_count_b: got group %0d expected no count", b_if.count_grp);
      end else begin
        check("count_grp_b", 32'(b_if.count_grp), 32'(exp_qb.pop_front()));
      end
    end
  end

  // stimulus
  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0;
    a_if.weight = '0; a_if.cfg_we = 1'b0; a_if.cfg_idx = '0; a_if.cfg_data = '0; a_if.clr_cnt = 1'b0;
    b_if.weight = '0; b_if.cfg_we = 1'b0; b_if.cfg_idx = '0; b_if.cfg_data = '0; b_if.clr_cnt = 1'b0;
    tick(2);
    check("rst_grp_cnt", 32'(a_if.grp_cnt == '0), 32'd1);
    check("rst_currgrp", 32'(a_if.currgrp), 32'd0);
    check("rst_count_grp", 32'(a_if.count_grp), 32'd0);
    check("rst_state", 32'(a_if.fsm_state), 32'd0);
    rst_n = 1'b1;

    // 1500 settles into group 4
    a_if.weight = 12'd1500; exp_q.push_back(3'd4);
    tick();
    check("settle_no_pulse", 32'(a_if.count_pulse), 32'd0);
    tick();
    check("g4_pulse", 32'(a_if.count_pulse), 32'd1);
    check("g4_cnt", 32'(cnt_a(4)), 32'd1);
    check("g4_count_grp", 32'(a_if.count_grp), 32'd4);
    check("g4_currgrp", 32'(a_if.currgrp), 32'd4);
    check("g4_prevweight", 32'(a_if.prevweight), 32'd1500);
    check("g4_state", 32'(a_if.fsm_state), 32'd2);

    // change without emptying: tracked but not counted
    a_if.weight = 12'd1650;
    tick();
    check("pulse_one_cycle", 32'(a_if.count_pulse), 32'd0);
    check("chg_currgrp", 32'(a_if.currgrp), 32'd5);
    tick(3);
    check("chg_no_recount", 32'(cnt_a(5)), 32'd0);
    a_if.weight = '0; tick();
    a_if.weight = 12'd1650; exp_q.push_back(3'd5);
    tick(2);
    check("g5_cnt", 32'(cnt_a(5)), 32'd1);
    check("g5_count_grp", 32'(a_if.count_grp), 32'd5);
    a_if.weight = '0; tick();

    // unsettled load never counts
    a_if.clr_cnt = 1'b1; tick(); a_if.clr_cnt = 1'b0;
    check("clr_all", 32'(a_if.grp_cnt == '0), 32'd1);
    for (int i = 0; i < 6; i++) begin
      a_if.weight = (i % 2 == 0) ? 12'd300 : 12'd301;
      tick();
    end
    a_if.weight = '0; tick();
    check("alt_no_count", 32'(a_if.grp_cnt == '0), 32'd1);

    // threshold write: T0=100 moves 241 into group 2
    a_if.cfg_we = 1'b1; a_if.cfg_idx = 3'd0; a_if.cfg_data = 12'd100;
    tick(); a_if.cfg_we = 1'b0;
    a_if.weight = 12'd241; exp_q.push_back(3'd2);
    tick(2);
    check("thr_g2_cnt", 32'(cnt_a(2)), 32'd1);
    check("thr_g1_cnt", 32'(cnt_a(1)), 32'd0);
    a_if.weight = '0; tick();
    // write coincident with the count edge: old threshold is used
    a_if.weight = 12'd241; exp_q.push_back(3'd2);
    tick();
    a_if.cfg_we = 1'b1; a_if.cfg_idx = 3'd0; a_if.cfg_data = 12'd250;
    tick(); a_if.cfg_we = 1'b0;
    check("wr_edge_g2_cnt", 32'(cnt_a(2)), 32'd2);
    check("wr_edge_g1_cnt", 32'(cnt_a(1)), 32'd0);
    check("wr_edge_currgrp", 32'(a_if.currgrp), 32'd2);
    tick();
    check("new_thr_currgrp", 32'(a_if.currgrp), 32'd1);
    // out-of-range indices ignored
    a_if.cfg_we = 1'b1; a_if.cfg_idx = 3'd5; a_if.cfg_data = 12'd1;
    tick(); a_if.cfg_idx = 3'd7; tick(); a_if.cfg_we = 1'b0;
    tick();
    check("oor_currgrp", 32'(a_if.currgrp), 32'd1);
    a_if.weight = 12'd600; tick();
    check("oor_t2_intact", 32'(a_if.currgrp), 32'd3);
    a_if.weight = '0; tick();

    // asynchronous reset mid-settling
    a_if.weight = 12'd600; tick();
    check("pre_rst_state", 32'(a_if.fsm_state), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_grp_cnt", 32'(a_if.grp_cnt == '0), 32'd1);
    check("arst_currgrp", 32'(a_if.currgrp), 32'd0);
    check("arst_prevweight", 32'(a_if.prevweight), 32'd0);
    check("arst_count_grp", 32'(a_if.count_grp), 32'd0);
    check("arst_state", 32'(a_if.fsm_state), 32'd0);
    tick();
    rst_n = 1'b1; exp_q.push_back(3'd3);
    tick();
    check("rel_no_count", 32'(cnt_a(3)), 32'd0);
    tick();
    check("rel_g3_cnt", 32'(cnt_a(3)), 32'd1);
    check("rel_count_grp", 32'(a_if.count_grp), 32'd3);
    check("rel_prevweight", 32'(a_if.prevweight), 32'd600);
    a_if.weight = '0; tick();

    // saturation on the 2-bit counter instance
    for (int k = 0; k < 4; k++) begin
      b_if.weight = 12'd2500; exp_qb.push_back(3'd6);
      tick(2);
      b_if.weight = '0; tick();
      check($sformatf("sat_cnt_%0d", k), 32'(b_if.grp_cnt[11:10]), (k < 3) ? 32'(k+1) : 32'd3);
      check($sformatf("sat_flag_%0d", k), 32'(b_if.grp_sat), (k < 3) ? 32'd0 : 32'h20);
    end
    // clear coincident with a count: clear wins, strobes still update
    b_if.weight = 12'd2500; exp_qb.push_back(3'd6);
    tick();
    b_if.clr_cnt = 1'b1;
    tick();
    b_if.clr_cnt = 1'b0;
    check("clr_win_cnt", 32'(b_if.grp_cnt == '0), 32'd1);
    check("clr_win_sat", 32'(b_if.grp_sat), 32'd0);
    check("clr_win_pulse", 32'(b_if.count_pulse), 32'd1);
    check("clr_win_grp", 32'(b_if.count_grp), 32'd6);
    b_if.weight = '0; tick(3);

    check("a_queue_drained", 32'(exp_q.size()), 32'd0);
    check("b_queue_drained", 32'(exp_qb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
